// File: rtl/alu_top.sv
// 32-bit ADD/SUB/AND/OR ALU with {N,Z,C,V} flags. Result and flags are combinational
// (zero latency), and a registered copy is provided one cycle later. No backpressure.
module alu_top (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [1:0]  ALUOp,
    output logic [31:0] Result,
    output logic [3:0]  ALUFlags,
    output logic [31:0] Result_q,
    output logic [3:0]  ALUFlags_q
);

    logic [31:0] b_eff;
    logic [31:0] sum;
    logic        carry_out;
    logic [31:0] Result_d;
    logic [3:0]  ALUFlags_d;

    // SUB reuses the adder: B is inverted and carry-in is 1 when ALUOp[0] is set.
    assign b_eff = B ^ {32{ALUOp[0]}};

    // Each stage has its own carry signals so the ripple chain never loops back into a single vector.
    for (genvar i = 0; i < 32; i++) begin : g_fa
        logic cin;
        logic cout;
        logic axb;
        logic gen;
        logic prop;

        if (i == 0) begin : g_cin0
            assign cin = ALUOp[0];
        end else begin : g_cinn
            assign cin = g_fa[i-1].cout;
        end

        xor u_x1 (axb, A[i], b_eff[i]);
        xor u_x2 (sum[i], axb, cin);
        and u_a1 (gen, A[i], b_eff[i]);
        and u_a2 (prop, axb, cin);
        or  u_o1 (cout, gen, prop);
    end

    assign carry_out = g_fa[31].cout;

    always_comb begin
        Result   = sum;
        ALUFlags = 4'b0000;
        if (ALUOp[1]) begin
            Result      = ALUOp[0] ? (A | B) : (A & B);
        end else begin
            ALUFlags[1] = carry_out;
            // b_eff already carries the SUB inversion, so one overflow equation covers both ops.
            ALUFlags[0] = ~(A[31] ^ b_eff[31]) & (A[31] ^ sum[31]);
        end
        ALUFlags[3] = Result[31];
        ALUFlags[2] = (Result == 32'h0);
    end

    always_comb begin
        Result_d   = Result;
        ALUFlags_d = ALUFlags;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Result_q   <= 32'h0;
            ALUFlags_q <= 4'b0000;
        end else begin
            Result_q   <= Result_d;
            ALUFlags_q <= ALUFlags_d;
        end
    end

endmodule

// File: tb/tb_alu_top.sv
// Bench for alu_top: directed vector table, random regression against an arithmetic
// reference model, and register/reset sequences.
module tb_alu_top;

    logic        clk;
    logic        rst;
    logic [31:0] A;
    logic [31:0] B;
    logic [1:0]  ALUOp;
    logic [31:0] Result;
    logic [3:0]  ALUFlags;
    logic [31:0] Result_q;
    logic [3:0]  ALUFlags_q;

    int checks;
    int failures;

    alu_top dut (
        .clk        (clk),
        .rst        (rst),
        .A          (A),
        .B          (B),
        .ALUOp      (ALUOp),
        .Result     (Result),
        .ALUFlags   (ALUFlags),
        .Result_q   (Result_q),
        .ALUFlags_q (ALUFlags_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic [31:0] exp_res;
        logic [3:0]  exp_flags;
    } vec_t;

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference computed from integer arithmetic: unsigned range for C, signed range for V.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                                  output logic [31:0] r, output logic [3:0] f);
        longint unsigned us;
        longint          ss;
        logic            c;
        logic            v;
        c = 1'b0;
        v = 1'b0;
        case (op)
            2'b00: begin
                us = 64'(a) + 64'(b);
                r  = us[31:0];
                c  = (us > 64'hFFFF_FFFF);
                ss = longint'($signed(a)) + longint'($signed(b));
                v  = (ss > SMAX) || (ss < SMIN);
            end
            2'b01: begin
                r  = a - b;
                c  = (a >= b);
                ss = longint'($signed(a)) - longint'($signed(b));
                v  = (ss > SMAX) || (ss < SMIN);
            end
            2'b10:   r = a & b;
            default: r = a | b;
        endcase
        f = {r[31], (r == 32'h0), c, v};
    endfunction

    vec_t vecs [8];

    initial begin
        logic [31:0] er;
        logic [3:0]  ef;
        int          fail_before;

        checks   = 0;
        failures = 0;

        vecs[0] = '{32'hFFFF_FFFF, 32'h0F0F_0F0F, 2'b10, 32'h0F0F_0F0F, 4'b0000};
        vecs[1] = '{32'h8000_0000, 32'h0000_0001, 2'b11, 32'h8000_0001, 4'b1000};
        vecs[2] = '{32'h0000_0001, 32'h0000_0001, 2'b00, 32'h0000_0002, 4'b0000};
        vecs[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 2'b00, 32'h8000_0000, 4'b1001};
        vecs[4] = '{32'hFFFF_FFFF, 32'h0000_0001, 2'b00, 32'h0000_0000, 4'b0110};
        vecs[5] = '{32'h0000_0003, 32'h0000_0002, 2'b01, 32'h0000_0001, 4'b0010};
        vecs[6] = '{32'h0000_0000, 32'h0000_0001, 2'b01, 32'hFFFF_FFFF, 4'b1000};
        vecs[7] = '{32'h8000_0000, 32'h0000_0001, 2'b01, 32'h7FFF_FFFF, 4'b0011};

        // Reset held from time 0: registered outputs must be clear with no clock edge yet.
        rst   = 1'b1;
        A     = 32'h0;
        B     = 32'h0;
        ALUOp = 2'b00;
        #1;
        chk("reset_result_q", Result_q, 32'h0);
        chk("reset_flags_q", {28'h0, ALUFlags_q}, 32'h0);

        // Combinational outputs stay live while reset is asserted.
        A = 32'h0000_0005; B = 32'h0000_0003; ALUOp = 2'b01;
        #1;
        chk("comb_in_reset_res", Result, 32'h0000_0002);
        chk("comb_in_reset_flg", {28'h0, ALUFlags}, {28'h0, 4'b0010});

        @(negedge clk);
        chk("reset_hold_across_edge", Result_q, 32'h0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            A = vecs[i].a; B = vecs[i].b; ALUOp = vecs[i].op;
            #1;
            chk($sformatf("vec%0d_result", i), Result, vecs[i].exp_res);
            chk($sformatf("vec%0d_flags", i), {28'h0, ALUFlags}, {28'h0, vecs[i].exp_flags});
        end

        for (int n = 0; n < 1000; n++) begin
            A     = $urandom;
            B     = $urandom;
            ALUOp = 2'($urandom_range(0, 3));
            if (n % 8 == 0) B = A;
            if (n % 16 == 1) A = 32'h8000_0000;
            #1;
            model(A, B, ALUOp, er, ef);
            fail_before = failures;
            chk($sformatf("rand%0d_result", n), Result, er);
            chk($sformatf("rand%0d_flags", n), {28'h0, ALUFlags}, {28'h0, ef});
            if (failures != fail_before) break;
        end

        // Register path: load a known nonzero value.
        @(negedge clk);
        A = 32'h0000_0001; B = 32'h0000_0001; ALUOp = 2'b00;
        @(posedge clk); #1;
        chk("reg_load_result_q", Result_q, 32'h0000_0002);
        chk("reg_load_flags_q", {28'h0, ALUFlags_q}, 32'h0);

        // Mid-cycle async reset clears immediately.
        @(negedge clk);
        A = 32'h7FFF_FFFF; ALUOp = 2'b00;
        @(posedge clk); #1;
        chk("reg_ovf_flags_q", {28'h0, ALUFlags_q}, {28'h0, 4'b1001});
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_result_q", Result_q, 32'h0);
        chk("async_rst_flags_q", {28'h0, ALUFlags_q}, 32'h0);

        @(negedge clk);
        rst = 1'b0;
        A = 32'h0000_0001; B = 32'h0000_0001; ALUOp = 2'b00;
        @(posedge clk); #1;
        chk("post_rst_load_q", Result_q, 32'h0000_0002);

        @(negedge clk);
        A = 32'hFFFF_FFFF; B = 32'h0000_0001; ALUOp = 2'b00;
        #1;
        chk("hold_before_edge_res_q", Result_q, 32'h0000_0002);
        chk("hold_before_edge_flg_q", {28'h0, ALUFlags_q}, 32'h0);
        @(posedge clk); #1;
        chk("after_edge_result_q", Result_q, 32'h0);
        chk("after_edge_flags_q", {28'h0, ALUFlags_q}, {28'h0, 4'b0110});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
